// File: rtl/bit_slice_serializer_if.sv
// CPU write/start port and slice output bus of the bit-slice serializer.
// The master side is the CPU/feeder; the slave side is the serializer itself.
interface bit_slice_serializer_if #(
   parameter int M = 32,
   parameter int N = 8
);
   localparam int AW = (M > 1) ? $clog2(M) : 1;

   logic          wr_en;
   logic [AW-1:0] wr_addr;
   logic [N-1:0]  wr_data;
   logic          start;
   logic          ready;
   logic          slice_vld;
   logic [M-1:0]  slice;
   logic          done;
   logic          wr_err;

   modport master (
      output wr_en, wr_addr, wr_data, start,
      input  ready, slice_vld, slice, done, wr_err
   );

   modport slave (
      input  wr_en, wr_addr, wr_data, start,
      output ready, slice_vld, slice, done, wr_err
   );
endinterface

// File: rtl/bit_slice_serializer.sv
// Buffers M words of N bits and streams them out as N gap-free M-bit
// column slices, LSB first, to feed a serial bit-slice adder.
module bit_slice_serializer #(
   parameter int M = 32,
   parameter int N = 8
) (
   input logic                  clk,
   input logic                  rst_p,
   bit_slice_serializer_if.slave bus
);
   localparam int         AW        = (M > 1) ? $clog2(M) : 1;
   localparam int         KW        = (N > 1) ? $clog2(N) : 1;
   localparam logic [KW-1:0] K_LAST = KW'(N - 1);
   localparam bit         ONE_SLICE = (N == 1);

   typedef enum logic [1:0] {IDLE, ARM, SHIFT, DONE} state_t;

   state_t                  state_q;
   logic [KW-1:0]           k_q;
   logic [M-1:0][N-1:0]     mem_q;
   logic [M-1:0]            slice_q;
   logic                    vld_q;
   logic                    done_q;
   logic                    err_q;

   logic [M-1:0]            col_d;
   logic                    addr_ok;

   // Only reachable with a non-power-of-2 M; otherwise constant true.
   assign addr_ok = ({1'b0, bus.wr_addr} < (AW + 1)'(M));

   // k_q is 0 in ARM, so the same selector serves the first and later columns.
   always_comb begin
      col_d = '0;
      for (int j = 0; j < M; j++) col_d[j] = mem_q[j][k_q];
   end

   always_ff @(posedge clk) begin
      if (rst_p) begin
         state_q <= IDLE;
         k_q     <= '0;
         mem_q   <= '0;
         slice_q <= '0;
         vld_q   <= 1'b0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         err_q  <= bus.wr_en && (!addr_ok || state_q != IDLE);
         done_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (bus.wr_en && addr_ok) mem_q[bus.wr_addr] <= bus.wr_data;
               if (bus.start) state_q <= ARM;
            end
            ARM: begin
               slice_q <= col_d;
               vld_q   <= 1'b1;
               if (ONE_SLICE) begin
                  state_q <= DONE;
               end else begin
                  k_q     <= KW'(1);
                  state_q <= SHIFT;
               end
            end
            SHIFT: begin
               slice_q <= col_d;
               vld_q   <= 1'b1;
               if (k_q == K_LAST) begin
                  k_q     <= '0;
                  state_q <= DONE;
               end else begin
                  k_q <= k_q + KW'(1);
               end
            end
            DONE: begin
               vld_q   <= 1'b0;
               done_q  <= 1'b1;
               state_q <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign bus.ready     = (state_q == IDLE);
   assign bus.slice_vld = vld_q;
   assign bus.slice     = slice_q;
   assign bus.done      = done_q;
   assign bus.wr_err    = err_q;
endmodule

// File: tb/tb_bit_slice_serializer.sv
// Directed bench for bit_slice_serializer: slice contents, timing, replay,
// busy-write rejection, write+start overlap and mid-run reset.
module tb_bit_slice_serializer;
   localparam int M = 32;
   localparam int N = 8;

   logic clk = 1'b0;
   logic rst_p;
   always #5 clk = ~clk;

   bit_slice_serializer_if #(.M(M), .N(N)) bus ();
   bit_slice_serializer #(.M(M), .N(N)) dut (.clk(clk), .rst_p(rst_p), .bus(bus));

   int n_chk = 0;
   int n_bad = 0;
   logic [M-1:0] got [16];
   int nsl;

   task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wr(input int a, input logic [N-1:0] d);
      bus.wr_en = 1'b1; bus.wr_addr = a[4:0]; bus.wr_data = d;
      tick();
      bus.wr_en = 1'b0;
   endtask

   function automatic int adder_sum();
      int s = 0;
      for (int k = 0; k < N; k++) s += $countones(got[k]) << k;
      return s;
   endfunction

   // act: 0 plain, 1 write word0 mid-run, 2 start pulse mid-run, 3 write word0=1 with start
   task automatic run(input int act);
      int guard;
      bus.start = 1'b1;
      if (act == 3) begin
         bus.wr_en = 1'b1; bus.wr_addr = '0; bus.wr_data = 8'h01;
      end
      tick();
      bus.start = 1'b0;
      bus.wr_en = 1'b0;
      chk("arm_ready", bus.ready, 0);
      chk("arm_vld", bus.slice_vld, 0);
      if (act == 3) chk("idle_wr_no_err", bus.wr_err, 0);
      tick();
      nsl = 0; guard = 0;
      while (bus.slice_vld && guard < 20) begin
         if (nsl < 16) got[nsl] = bus.slice;
         chk("busy_ready", bus.ready, 0);
         if (act == 1 && nsl == 2) begin
            bus.wr_en = 1'b1; bus.wr_addr = '0; bus.wr_data = 8'h00;
         end
         if (act == 1 && nsl == 3) begin
            chk("busy_wr_err", bus.wr_err, 1);
            bus.wr_en = 1'b0;
         end
         if (act == 1 && nsl == 4) chk("busy_wr_err_pulse", bus.wr_err, 0);
         if (act == 2) bus.start = (nsl == 2);
         nsl++; guard++;
         tick();
      end
      bus.start = 1'b0;
      chk("nslices", nsl, N);
      chk("done_pulse", bus.done, 1);
      chk("done_ready", bus.ready, 1);
   endtask

   logic [M-1:0] exp_cnt [8];

   initial begin
      exp_cnt = '{32'hAAAAAAAA, 32'hCCCCCCCC, 32'hF0F0F0F0, 32'hFF00FF00,
                  32'hFFFF0000, 32'h00000000, 32'h00000000, 32'h00000000};
      rst_p = 1'b1;
      bus.wr_en = 1'b0; bus.wr_addr = '0; bus.wr_data = '0; bus.start = 1'b0;
      tick(); tick();
      rst_p = 1'b0;
      chk("rst_ready", bus.ready, 1);
      chk("rst_vld", bus.slice_vld, 0);
      chk("rst_done", bus.done, 0);
      chk("rst_err", bus.wr_err, 0);
      chk("rst_slice", bus.slice, 0);

      // counting pattern
      for (int j = 0; j < M; j++) wr(j, j[7:0]);
      run(0);
      for (int k = 0; k < N; k++) chk($sformatf("cnt_slice%0d", k), got[k], exp_cnt[k]);
      chk("cnt_sum", adder_sum(), 496);
      tick();
      chk("done_one_cycle", bus.done, 0);
      chk("hold_slice", bus.slice, 0);

      // all ones, then back-to-back replay started in the done cycle
      for (int j = 0; j < M; j++) wr(j, 8'hFF);
      run(0);
      for (int k = 0; k < N; k++) chk($sformatf("ones_slice%0d", k), got[k], 32'hFFFFFFFF);
      chk("ones_sum", adder_sum(), 8160);
      run(0);
      for (int k = 0; k < N; k++) chk($sformatf("replay_slice%0d", k), got[k], 32'hFFFFFFFF);
      chk("replay_sum", adder_sum(), 8160);

      // write while busy is rejected
      run(1);
      chk("busy_run_slice3", got[3], 32'hFFFFFFFF);
      tick();
      run(0);
      chk("busy_replay_bit0", got[0][0], 1);
      chk("busy_replay_sum", adder_sum(), 8160);

      // start during SHIFT is ignored, no extra run
      tick();
      run(2);
      for (int i = 0; i < 4; i++) begin
         tick();
         chk("no_extra_run", bus.slice_vld, 0);
      end

      // simultaneous write and start from a zeroed buffer
      rst_p = 1'b1; tick(); rst_p = 1'b0;
      run(3);
      chk("sim_slice0", got[0], 32'h00000001);
      for (int k = 1; k < N; k++) chk($sformatf("sim_slice%0d", k), got[k], 0);

      // reset while third slice is out
      tick();
      bus.start = 1'b1; tick(); bus.start = 1'b0;
      tick(); tick(); tick();
      chk("mid_vld_before", bus.slice_vld, 1);
      rst_p = 1'b1; tick(); rst_p = 1'b0;
      chk("mid_rst_vld", bus.slice_vld, 0);
      chk("mid_rst_ready", bus.ready, 1);
      chk("mid_rst_done", bus.done, 0);
      chk("mid_rst_slice", bus.slice, 0);
      tick();
      chk("mid_rst_no_done", bus.done, 0);
      run(0);
      for (int k = 0; k < N; k++) chk($sformatf("post_rst_slice%0d", k), got[k], 0);

      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end
endmodule
